// File: rtl/ip_rx_pkg.sv
// ip_rx_pkg: shared types and constants for the IPv4 receive dispatcher
package ip_rx_pkg;
  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, PAD, DROP} state_t;
  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IHL_MIN = 4'd5;
  localparam logic [31:0] BCAST_IP = 32'hFFFF_FFFF;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] OFF_TOTLEN = 16'd2;
  localparam logic [15:0] OFF_PROTO = 16'd9;
  localparam logic [15:0] OFF_SRC = 16'd12;
  localparam logic [15:0] OFF_DST = 16'd16;
endpackage

// File: rtl/ip_rx_dispatch_if.sv
// ip_rx_dispatch_if: MAC-side byte stream in, payload byte stream out
interface ip_rx_dispatch_if #(parameter int NUM_PROTO = 2);
  logic rx_valid;
  logic [7:0] rx_data;
  logic rx_sof;
  logic rx_eof;
  logic pl_valid;
  logic [7:0] pl_data;
  logic pl_sof;
  logic pl_eof;
  logic pl_err;
  logic [NUM_PROTO-1:0] pl_sel;
  modport master (output rx_valid, rx_data, rx_sof, rx_eof, input pl_valid, pl_data, pl_sof, pl_eof, pl_err, pl_sel);
  modport slave (input rx_valid, rx_data, rx_sof, rx_eof, output pl_valid, pl_data, pl_sof, pl_eof, pl_err, pl_sel);
endinterface

// File: rtl/ip_hdr_csum.sv
// ip_hdr_csum: ones-complement header sum over big-endian words, end-around carry per word
module ip_hdr_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       sum_ok
);
  logic [15:0] acc;
  logic [7:0] hi;
  logic odd;
  logic [16:0] s;
  logic [15:0] folded;
  assign s = {1'b0, acc} + {1'b0, hi, data};
  assign folded = s[15:0] + {15'd0, s[16]};
  // sum_ok already includes the word completed by the current byte so the header end can decide in-cycle
  assign sum_ok = ((valid & odd & ~clr) ? folded : acc) == 16'hFFFF;
  // accumulate: even bytes park as the high half, odd bytes complete a word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      hi <= '0;
      odd <= 1'b0;
    end else if (valid & clr) begin
      acc <= '0;
      hi <= data;
      odd <= 1'b1;
    end else if (valid) begin
      acc <= odd ? folded : acc;
      hi <= odd ? hi : data;
      odd <= ~odd;
    end
endmodule

// File: rtl/ip_rx_dispatch.sv
// ip_rx_dispatch: IPv4 header check/strip and one-hot protocol dispatch of the payload
module ip_rx_dispatch
  import ip_rx_pkg::*;
#(
  parameter int NUM_PROTO = 2,
  parameter logic [NUM_PROTO*8-1:0] PROTO_LIST = {8'h11, 8'h01},
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] local_ip_addr,
  input  logic [47:0] local_mac_addr,
  input  logic [47:0] mac_dst_addr,
  ip_rx_dispatch_if.slave bus,
  output logic [15:0] pl_len,
  output logic [7:0]  protocol,
  output logic [31:0] src_ip,
  output logic [31:0] dst_ip,
  output logic        hdr_done,
  output logic        err_checksum,
  output logic        err_addr,
  output logic        err_hdr
);
  state_t state, nxt;
  logic [15:0] cnt, tot_len, hdr_len;
  logic [3:0] ihl;
  logic [NUM_PROTO-1:0] hit, sel_q;
  logic [31:0] dst_cur;
  logic [7:0] pd;
  logic pv, ps, pe, perr;
  logic start, bad_ver, in_hdr, in_pay, hdr_last, pay_last, sum_ok;
  logic chk_hdr, chk_cs, chk_addr, hdr_good, pay, addr_bad;
  logic fwd, last, abort_pl, done, go_pay, e_hdr, e_cs, e_addr;

  for (genvar i = 0; i < NUM_PROTO; i++) begin : g_hit
    assign hit[i] = protocol == PROTO_LIST[8*i +: 8];
  end

  assign start = bus.rx_valid & bus.rx_sof;
  assign bad_ver = bus.rx_data[7:4] != IPV4_VERSION || bus.rx_data[3:0] < IHL_MIN;
  assign in_hdr = bus.rx_valid & ~bus.rx_sof & state == HDR;
  assign in_pay = bus.rx_valid & ~bus.rx_sof & state == PAYLOAD;
  assign hdr_len = {10'd0, ihl, 2'b00};
  assign hdr_last = cnt == hdr_len - 16'd1;
  assign pay_last = cnt == tot_len - 16'd1;
  assign dst_cur = cnt == OFF_DST + 16'd3 ? {dst_ip[23:0], bus.rx_data} : dst_ip;
  assign addr_bad = !((dst_cur == local_ip_addr || (ACCEPT_BCAST && dst_cur == BCAST_IP)) &&
                      (mac_dst_addr == local_mac_addr || (ACCEPT_BCAST && mac_dst_addr == BCAST_MAC)));
  assign chk_hdr = tot_len < hdr_len;
  assign chk_cs = ~chk_hdr & ~sum_ok;
  assign chk_addr = ~chk_hdr & sum_ok & addr_bad;
  assign hdr_good = ~chk_hdr & sum_ok & ~addr_bad;
  assign pay = hdr_good & |hit & tot_len != hdr_len;

  ip_hdr_csum u_csum (
    .clk(clk),
    .rst_n(rst_n),
    .clr(start),
    .valid(start | in_hdr),
    .data(bus.rx_data),
    .sum_ok(sum_ok)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;

  // next state: sof always restarts a header; eof always ends the frame
  always_comb begin
    nxt = state;
    if (start) nxt = bus.rx_eof ? IDLE : bad_ver ? DROP : HDR;
    else if (bus.rx_valid)
      case (state)
        HDR: nxt = bus.rx_eof ? IDLE : hdr_last ? (pay ? PAYLOAD : DROP) : HDR;
        PAYLOAD: nxt = bus.rx_eof ? IDLE : pay_last ? PAD : PAYLOAD;
        PAD, DROP: nxt = bus.rx_eof ? IDLE : state;
        default: nxt = state;
      endcase
  end

  // output events: forwarding, abort marker and the single error/done pulse per header
  always_comb begin
    fwd = in_pay & (pay_last | ~bus.rx_eof);
    last = in_pay & pay_last;
    abort_pl = state == PAYLOAD & bus.rx_valid & (bus.rx_sof | (bus.rx_eof & ~pay_last));
    e_hdr = (start & (bad_ver | bus.rx_eof | state == HDR)) |
            (in_hdr & (hdr_last ? (chk_hdr | (pay & bus.rx_eof)) : bus.rx_eof));
    e_cs = in_hdr & hdr_last & chk_cs;
    e_addr = in_hdr & hdr_last & chk_addr;
    done = in_hdr & hdr_last & hdr_good & |hit & ~(pay & bus.rx_eof);
    go_pay = done & pay;
  end

  // header field capture and byte counter (counter only runs while bytes matter)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ihl <= '0;
      tot_len <= '0;
      protocol <= '0;
      src_ip <= '0;
      dst_ip <= '0;
    end else if (start) begin
      cnt <= 16'd1;
      ihl <= bus.rx_data[3:0];
    end else begin
      if (in_hdr | in_pay) cnt <= cnt + 16'd1;
      if (in_hdr && cnt == OFF_TOTLEN) tot_len[15:8] <= bus.rx_data;
      if (in_hdr && cnt == OFF_TOTLEN + 16'd1) tot_len[7:0] <= bus.rx_data;
      if (in_hdr && cnt == OFF_PROTO) protocol <= bus.rx_data;
      if (in_hdr && cnt >= OFF_SRC && cnt < OFF_DST) src_ip <= {src_ip[23:0], bus.rx_data};
      if (in_hdr && cnt >= OFF_DST && cnt < OFF_DST + 16'd4) dst_ip <= {dst_ip[23:0], bus.rx_data};
    end

  // registered payload stream and status pulses, one cycle behind the input byte
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= 1'b0;
      pd <= '0;
      ps <= 1'b0;
      pe <= 1'b0;
      perr <= 1'b0;
      sel_q <= '0;
      pl_len <= '0;
      hdr_done <= 1'b0;
      err_checksum <= 1'b0;
      err_addr <= 1'b0;
      err_hdr <= 1'b0;
    end else begin
      pv <= fwd;
      pd <= fwd ? bus.rx_data : 8'h00;
      ps <= fwd & cnt == hdr_len;
      pe <= last | abort_pl;
      perr <= abort_pl;
      sel_q <= go_pay ? hit : pe ? '0 : sel_q;
      pl_len <= done ? tot_len - hdr_len : pl_len;
      hdr_done <= done;
      err_checksum <= e_cs;
      err_addr <= e_addr;
      err_hdr <= e_hdr;
    end

  assign bus.pl_valid = pv;
  assign bus.pl_data = pd;
  assign bus.pl_sof = ps;
  assign bus.pl_eof = pe;
  assign bus.pl_err = perr;
  assign bus.pl_sel = sel_q;
endmodule

// File: tb/tb_ip_rx_dispatch.sv
// tb_ip_rx_dispatch: directed IPv4 dispatch scenarios with immediate-assertion checks
module tb_ip_rx_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] local_ip = 32'h0A00_0001;
  logic [47:0] local_mac = 48'h0200_0000_0001;
  logic [47:0] mac_dst;
  logic [15:0] len0, len1;
  logic [7:0] proto0, proto1;
  logic [31:0] src0, dst0, src1, dst1;
  logic done0, ecs0, eaddr0, ehdr0, done1, ecs1, eaddr1, ehdr1;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic mon_clr = 1'b0;
  int n_pl, n_sof, n_eof, n_err, eof_at, n_done, n_ecs, n_eaddr, n_ehdr;
  int done_cyc, ehdr_cyc, first_cyc, n_done1, n_eaddr1, n_pl1;
  logic [7:0] pl_x, exp_x;
  logic [1:0] sel_d;
  logic [15:0] len_d;
  logic [7:0] pkt [0:255];
  int b_cyc [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ip_rx_dispatch_if #(.NUM_PROTO(2)) b0 ();
  ip_rx_dispatch_if #(.NUM_PROTO(2)) b1 ();
  assign b1.rx_valid = b0.rx_valid;
  assign b1.rx_data = b0.rx_data;
  assign b1.rx_sof = b0.rx_sof;
  assign b1.rx_eof = b0.rx_eof;

  ip_rx_dispatch #(.NUM_PROTO(2), .PROTO_LIST(16'h1101), .ACCEPT_BCAST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .local_ip_addr(local_ip), .local_mac_addr(local_mac),
    .mac_dst_addr(mac_dst), .bus(b0), .pl_len(len0), .protocol(proto0), .src_ip(src0),
    .dst_ip(dst0), .hdr_done(done0), .err_checksum(ecs0), .err_addr(eaddr0), .err_hdr(ehdr0));

  ip_rx_dispatch #(.NUM_PROTO(2), .PROTO_LIST(16'h1101), .ACCEPT_BCAST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .local_ip_addr(local_ip), .local_mac_addr(local_mac),
    .mac_dst_addr(mac_dst), .bus(b1), .pl_len(len1), .protocol(proto1), .src_ip(src1),
    .dst_ip(dst1), .hdr_done(done1), .err_checksum(ecs1), .err_addr(eaddr1), .err_hdr(ehdr1));

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_clr) begin
      n_pl <= 0; n_sof <= 0; n_eof <= 0; n_err <= 0; eof_at <= 0; n_done <= 0;
      n_ecs <= 0; n_eaddr <= 0; n_ehdr <= 0; done_cyc <= 0; ehdr_cyc <= 0; first_cyc <= 0;
      n_done1 <= 0; n_eaddr1 <= 0; n_pl1 <= 0; pl_x <= 8'h00; sel_d <= 2'b00; len_d <= 16'h0;
    end else begin
      if (b0.pl_valid) begin
        if (n_pl == 0) first_cyc <= cyc;
        n_pl <= n_pl + 1;
        pl_x <= pl_x ^ b0.pl_data;
      end
      if (b0.pl_sof) n_sof <= n_sof + 1;
      if (b0.pl_eof) begin
        n_eof <= n_eof + 1;
        eof_at <= n_pl + (b0.pl_valid ? 1 : 0);
      end
      if (b0.pl_err) n_err <= n_err + 1;
      if (done0) begin
        n_done <= n_done + 1;
        done_cyc <= cyc;
        sel_d <= b0.pl_sel;
        len_d <= len0;
      end
      if (ecs0) n_ecs <= n_ecs + 1;
      if (eaddr0) n_eaddr <= n_eaddr + 1;
      if (ehdr0) begin
        if (n_ehdr == 0) ehdr_cyc <= cyc;
        n_ehdr <= n_ehdr + 1;
      end
      if (done1) n_done1 <= n_done1 + 1;
      if (eaddr1) n_eaddr1 <= n_eaddr1 + 1;
      if (b1.pl_valid) n_pl1 <= n_pl1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] csum16(input int n);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < n / 2; i++) s = s + {16'h0, pkt[2*i], pkt[2*i+1]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input int tl,
                       input logic [7:0] pr, input logic [31:0] dst, input int n);
    int h = int'(ihl) * 4;
    logic [15:0] c;
    for (int i = 0; i < n; i++) pkt[i] = 8'hA0 ^ i[7:0];
    pkt[0] = {ver, ihl}; pkt[1] = 8'h00; pkt[2] = tl[15:8]; pkt[3] = tl[7:0];
    pkt[4] = 8'h12; pkt[5] = 8'h34; pkt[6] = 8'h40; pkt[7] = 8'h00;
    pkt[8] = 8'h40; pkt[9] = pr; pkt[10] = 8'h00; pkt[11] = 8'h00;
    pkt[12] = 8'hC0; pkt[13] = 8'hA8; pkt[14] = 8'h01; pkt[15] = 8'h05;
    pkt[16] = dst[31:24]; pkt[17] = dst[23:16]; pkt[18] = dst[15:8]; pkt[19] = dst[7:0];
    for (int i = 20; i < h; i++) pkt[i] = i[7:0];
    c = csum16(h);
    pkt[10] = c[15:8];
    pkt[11] = c[7:0];
    exp_x = 8'h00;
    for (int i = h; i < tl && i < n; i++) exp_x = exp_x ^ pkt[i];
  endtask

  task automatic send(input int n, input bit eof_end, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && i % 3 == 2) begin
        @(negedge clk);
        b0.rx_valid = 1'b0; b0.rx_sof = 1'b0; b0.rx_eof = 1'b0;
      end
      @(negedge clk);
      b0.rx_valid = 1'b1;
      b0.rx_data = pkt[i];
      b0.rx_sof = i == 0;
      b0.rx_eof = eof_end && i == n - 1;
      b_cyc[i] = cyc;
    end
    @(negedge clk);
    b0.rx_valid = 1'b0; b0.rx_sof = 1'b0; b0.rx_eof = 1'b0;
  endtask

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    b0.rx_valid = 1'b0; b0.rx_data = 8'h00; b0.rx_sof = 1'b0; b0.rx_eof = 1'b0;
    mac_dst = local_mac;
    idle(3);
    chk("rst_pl_valid", b0.pl_valid, 0);
    chk("rst_pl_sel", b0.pl_sel, 0);
    chk("rst_pl_len", len0, 0);
    chk("rst_hdr_done", done0, 0);
    chk("rst_src_ip", src0, 0);
    chk("rst_err", {ehdr0, ecs0, eaddr0}, 0);
    rst_n = 1'b1;
    idle(2);

    clear_mon(); build(4'd4, 4'd5, 28, 8'h11, local_ip, 28); send(28, 1, 0); idle(4);
    chk("udp_done_cnt", n_done, 1);
    chk("udp_done_time", done_cyc, b_cyc[19] + 1);
    chk("udp_sel", sel_d, 2'b10);
    chk("udp_len", len_d, 16'd8);
    chk("udp_bytes", n_pl, 8);
    chk("udp_lag", first_cyc, b_cyc[20] + 1);
    chk("udp_sof", n_sof, 1);
    chk("udp_eof_at", eof_at, 8);
    chk("udp_data", pl_x, exp_x);
    chk("udp_errs", n_ecs + n_eaddr + n_ehdr + n_err, 0);
    chk("udp_src", src0, 32'hC0A8_0105);
    chk("udp_proto", proto0, 8'h11);
    chk("udp_sel_clear", b0.pl_sel, 2'b00);

    clear_mon(); build(4'd4, 4'd7, 40, 8'h01, local_ip, 46); send(46, 1, 1); idle(4);
    chk("icmp_sel", sel_d, 2'b01);
    chk("icmp_len", len_d, 16'd12);
    chk("icmp_bytes", n_pl, 12);
    chk("icmp_eof_at", eof_at, 12);
    chk("icmp_data", pl_x, exp_x);
    chk("icmp_errs", n_ecs + n_eaddr + n_ehdr + n_err, 0);

    clear_mon(); build(4'd4, 4'd5, 28, 8'h11, 32'h0A00_0099, 28); pkt[11] = pkt[11] ^ 8'h5A;
    send(28, 1, 0); idle(4);
    chk("cs_err", n_ecs, 1);
    chk("cs_no_addr", n_eaddr, 0);
    chk("cs_no_hdr", n_ehdr, 0);
    chk("cs_no_done", n_done, 0);
    chk("cs_no_pl", n_pl, 0);

    clear_mon(); mac_dst = 48'hFFFF_FFFF_FFFF; build(4'd4, 4'd5, 28, 8'h11, 32'hFFFF_FFFF, 28);
    send(28, 1, 0); idle(4); mac_dst = local_mac;
    chk("bc_done", n_done, 1);
    chk("bc_bytes", n_pl, 8);
    chk("bc_no_addr", n_eaddr, 0);
    chk("nobc_addr", n_eaddr1, 1);
    chk("nobc_done", n_done1, 0);
    chk("nobc_pl", n_pl1, 0);

    clear_mon(); build(4'd4, 4'd5, 28, 8'h06, local_ip, 28); send(28, 1, 0); idle(4);
    chk("tcp_done", n_done, 0);
    chk("tcp_errs", n_ecs + n_eaddr + n_ehdr, 0);
    chk("tcp_pl", n_pl, 0);

    clear_mon(); build(4'd6, 4'd5, 28, 8'h11, local_ip, 28); send(28, 1, 0); idle(4);
    chk("v6_hdr", n_ehdr, 1);
    chk("v6_time", ehdr_cyc, b_cyc[0] + 1);
    chk("v6_other", n_ecs + n_eaddr + n_done + n_pl, 0);

    clear_mon(); build(4'd4, 4'd5, 100, 8'h11, local_ip, 60); send(60, 1, 0); idle(4);
    chk("trunc_bytes", n_pl, 39);
    chk("trunc_eof", n_eof, 1);
    chk("trunc_err", n_err, 1);
    chk("trunc_eof_at", eof_at, 39);

    clear_mon(); build(4'd4, 4'd5, 100, 8'h11, local_ip, 30); send(30, 0, 0);
    build(4'd4, 4'd5, 28, 8'h11, local_ip, 28); send(28, 1, 0); idle(4);
    chk("sof_abort_err", n_err, 1);
    chk("sof_eofs", n_eof, 2);
    chk("sof_dones", n_done, 2);
    chk("sof_bytes", n_pl, 18);
    chk("sof_sofs", n_sof, 2);

    clear_mon(); build(4'd4, 4'd5, 20, 8'h11, local_ip, 20); send(20, 1, 0); idle(4);
    chk("zero_done", n_done, 1);
    chk("zero_len", len_d, 16'd0);
    chk("zero_sel", sel_d, 2'b00);
    chk("zero_pl", n_pl, 0);
    chk("zero_errs", n_ecs + n_eaddr + n_ehdr, 0);

    clear_mon(); build(4'd4, 4'd15, 62, 8'h01, local_ip, 62); send(62, 1, 0); idle(4);
    chk("ihl15_bytes", n_pl, 2);
    chk("ihl15_len", len_d, 16'd2);
    chk("ihl15_sel", sel_d, 2'b01);
    chk("ihl15_errs", n_ecs + n_eaddr + n_ehdr, 0);

    clear_mon(); build(4'd4, 4'd5, 100, 8'h11, local_ip, 25); send(25, 0, 0);
    chk("prerst_valid", b0.pl_valid, 1);
    chk("prerst_sel", b0.pl_sel, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", b0.pl_valid, 0);
    chk("arst_sel", b0.pl_sel, 0);
    chk("arst_len", len0, 0);
    chk("arst_dst", dst0, 0);
    chk("arst_proto", proto0, 0);
    @(negedge clk); rst_n = 1'b1;
    clear_mon(); build(4'd4, 4'd5, 28, 8'h11, local_ip, 28); send(28, 1, 0); idle(4);
    chk("post_rst_done", n_done, 1);
    chk("post_rst_bytes", n_pl, 8);
    chk("post_rst_eof", n_eof, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
